// File: rtl/pixel_repeat_x3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_repeat_x3_pkg
// Description : Shared types and default constants for the 3x nearest-
//               neighbour pixel upscaler (state encoding, default pixel
//               width and maximum source line length).
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_repeat_x3_pkg;

    // Default pixel width (RGB888) and maximum source line length
    localparam int c_DATA_W = 24;
    localparam int c_MAX_W  = 640;

    // LIVE   : pass 0, pixels stream straight from the source
    // REPLAY : passes 1 and 2, pixels stream from the line buffer
    typedef enum logic [0:0] {
        LIVE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

endpackage : pixel_repeat_x3_pkg
`default_nettype wire

// File: rtl/pixel_repeat_x3_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_repeat_x3_if
// Description : Valid/ready pixel stream with end-of-line marker.
//               master : drives valid, data, last; samples ready
//               slave  : samples valid, data, last; drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_repeat_x3_if
    import pixel_repeat_x3_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);

endinterface : pixel_repeat_x3_if
`default_nettype wire

// File: rtl/line_buf_sp.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_sp
// Description : Simple dual-port line buffer, one write port and one
//               synchronous read port (1-cycle latency). No reset on the
//               array or read register so it maps onto block RAM.
// Ports       : clk      - clock
//               i_we     - write enable      i_waddr/i_wdata - write port
//               i_re     - read enable       i_raddr         - read address
//               o_rdata  - read data, holds its value while i_re is low
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf_sp #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule : line_buf_sp
`default_nettype wire

// File: rtl/pixel_repeat_x3.sv
`default_nettype none
// ============================================================================
// Module      : pixel_repeat_x3
// Description : Nearest-neighbour 3x upscaler. Each source line of N pixels
//               becomes 3 output lines of 3N pixels. Pass 0 is streamed
//               live from the source while being stored in a line buffer;
//               passes 1 and 2 are replayed from the buffer.
// Ports       : clk   - clock (rising edge)
//               rst_n - asynchronous active-low reset
//               s     - source stream (slave), low-rate side
//               m     - upscaled stream (master), full-rate side
//               ovf   - sticky: a source line exceeded MAX_W pixels
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_repeat_x3
    import pixel_repeat_x3_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int MAX_W  = c_MAX_W,
    parameter int ADDR_W = 10
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pixel_repeat_x3_if.slave  s,
    pixel_repeat_x3_if.master m,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MAX_W - 1);

    state_t              r_state;
    logic [1:0]          r_rep;
    logic [1:0]          r_pass;
    logic                r_m_valid;
    logic                r_m_last;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_cur_last;   // pixel in the output register ends the line
    logic                r_load;       // replay pass start: take first pixel from RAM
    logic                r_drop;       // discarding the tail of an overlong line
    logic                r_ovf;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W:0]     r_rd_cnt;     // next buffer index to read
    logic [ADDR_W:0]     r_line_len;

    logic                w_m_hs;
    logic                w_s_ready;
    logic                w_s_hs;
    logic                w_wr_en;
    logic                w_forced;
    logic                w_line_end;
    logic                w_rd_first;
    logic                w_rd_next;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [DATA_W-1:0]   w_rd_q;

    assign w_m_hs    = r_m_valid && m.ready;
    // A new source pixel may replace the held one on its third output, but
    // never once the line's final pixel is held (replay must follow first).
    assign w_s_ready = (r_state == LIVE) &&
                       (!r_m_valid || (r_rep == 2'd2 && m.ready && !r_cur_last));
    assign w_s_hs    = s.valid && w_s_ready;
    assign w_wr_en   = w_s_hs && !r_drop;
    assign w_forced  = (r_wr_addr == c_LAST_ADDR);

    // The first read of a replay pass is issued on the m_last handshake of
    // the previous pass; later reads are issued one pixel ahead (rep==1) so
    // the RAM latency is hidden behind rep==2.
    assign w_line_end = w_m_hs && (r_rep == 2'd2) && r_cur_last;
    assign w_rd_first = w_line_end && ((r_state == LIVE) || (r_pass == 2'd1));
    assign w_rd_next  = (r_state == REPLAY) && w_m_hs && (r_rep == 2'd1) && !r_cur_last;
    assign w_rd_en    = w_rd_first || w_rd_next;
    assign w_rd_addr  = w_rd_first ? '0 : r_rd_cnt[ADDR_W-1:0];

    line_buf_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_addr),
        .i_wdata (s.data),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LIVE;
            r_rep      <= 2'd0;
            r_pass     <= 2'd0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
            r_cur_last <= 1'b0;
            r_load     <= 1'b0;
            r_drop     <= 1'b0;
            r_ovf      <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_cnt   <= '0;
            r_line_len <= '0;
        end else begin
            case (r_state)
                LIVE: begin
                    if (w_m_hs) begin
                        if (r_rep == 2'd2) begin
                            r_rep     <= 2'd0;
                            r_m_last  <= 1'b0;
                            r_m_valid <= 1'b0;
                            if (r_cur_last) begin
                                r_state  <= REPLAY;
                                r_pass   <= 2'd1;
                                r_load   <= 1'b1;
                                r_rd_cnt <= (ADDR_W+1)'(1);
                            end
                        end else begin
                            r_rep    <= r_rep + 2'd1;
                            r_m_last <= (r_rep == 2'd1) && r_cur_last;
                        end
                    end
                    if (w_s_hs) begin
                        if (r_drop) begin
                            if (s.last) begin
                                r_drop <= 1'b0;
                            end
                        end else begin
                            r_m_data   <= s.data;
                            r_m_valid  <= 1'b1;
                            r_rep      <= 2'd0;
                            r_m_last   <= 1'b0;
                            r_wr_addr  <= r_wr_addr + ADDR_W'(1);
                            r_cur_last <= s.last || w_forced;
                            if (s.last || w_forced) begin
                                r_line_len <= {1'b0, r_wr_addr} + (ADDR_W+1)'(1);
                            end
                            // Buffer full without end-of-line: close the line
                            // here and swallow the remainder later.
                            if (w_forced && !s.last) begin
                                r_ovf  <= 1'b1;
                                r_drop <= 1'b1;
                            end
                        end
                    end
                end

                REPLAY: begin
                    if (r_load) begin
                        r_load     <= 1'b0;
                        r_m_data   <= w_rd_q;
                        r_m_valid  <= 1'b1;
                        r_rep      <= 2'd0;
                        r_m_last   <= 1'b0;
                        r_cur_last <= (r_rd_cnt == r_line_len);
                    end else if (w_m_hs) begin
                        case (r_rep)
                            2'd0: begin
                                r_rep <= 2'd1;
                            end
                            2'd1: begin
                                r_rep    <= 2'd2;
                                r_m_last <= r_cur_last;
                                if (!r_cur_last) begin
                                    r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
                                end
                            end
                            default: begin
                                r_rep    <= 2'd0;
                                r_m_last <= 1'b0;
                                if (!r_cur_last) begin
                                    // Next pixel was read ahead on rep==1
                                    r_m_data   <= w_rd_q;
                                    r_cur_last <= (r_rd_cnt == r_line_len);
                                end else if (r_pass == 2'd1) begin
                                    r_pass    <= 2'd2;
                                    r_m_valid <= 1'b0;
                                    r_load    <= 1'b1;
                                    r_rd_cnt  <= (ADDR_W+1)'(1);
                                end else begin
                                    r_state    <= LIVE;
                                    r_pass     <= 2'd0;
                                    r_m_valid  <= 1'b0;
                                    r_cur_last <= 1'b0;
                                    r_wr_addr  <= '0;
                                    r_rd_cnt   <= '0;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    r_state <= LIVE;
                end
            endcase
        end
    end

    assign s.ready = w_s_ready;
    assign m.valid = r_m_valid;
    assign m.data  = r_m_data;
    assign m.last  = r_m_last;
    assign ovf     = r_ovf;

endmodule : pixel_repeat_x3
`default_nettype wire
